fetch_stage: RTL

Instruction fetch stage that sits directly upstream of the instruction cache. It owns the program counter and issues one single-cycle fetch pulse per instruction. It accepts the cache's same-cycle (hit) or delayed (miss) acknowledge and presents the instruction/PC pair to decode through a one-entry valid/ready output register. It also handles branch/jump redirects from execute, including discarding a cache response that is already in flight.

---
 rtl/fetch_stage.sv | 127 ++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues single-cycle fetch pulses to the
// icache and presents instruction/PC pairs to decode via a one-entry output register.
//
// state  | meaning
// -------+----------------------------------------------------------
// ISSUE  | free to pulse a fetch at pc_q when the output slot can take it
// WAIT   | one request outstanding at req_pc_q, waiting for ic_ack
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] ic_addr,
    output logic        ic_send_pulse,
    input  logic [31:0] ic_inst,
    input  logic        ic_ack,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    input  logic        id_ready
);

    typedef enum logic [0:0] {
        S_ISSUE = 1'b0,
        S_WAIT  = 1'b1
    } state_e;

    state_e      state_q,    state_d;
    logic [31:0] pc_q,       pc_d;
    logic [31:0] req_pc_q,   req_pc_d;
    logic        discard_q,  discard_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_inst_q,  if_inst_d;
    logic [31:0] if_pc_q,    if_pc_d;

    logic        can_accept;
    logic        pulse;
    logic [31:0] redirect_tgt;

    assign can_accept   = !if_valid_q || id_ready;
    assign redirect_tgt = {redirect_pc[31:2], 2'b00};

    // Issuing only when the slot will be free guarantees every ack can be captured.
    assign pulse = rst_n && (state_q == S_ISSUE) && can_accept && !redirect_valid;

    assign ic_send_pulse = pulse;
    assign ic_addr       = (state_q == S_WAIT) ? req_pc_q : pc_q;
    assign if_valid      = if_valid_q;
    assign if_inst       = if_inst_q;
    assign if_pc         = if_pc_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        discard_d  = discard_q;
        if_valid_d = if_valid_q && !id_ready;
        if_inst_d  = if_inst_q;
        if_pc_d    = if_pc_q;

        if (redirect_valid) begin
            pc_d       = redirect_tgt;
            if_valid_d = 1'b0;
            if (state_q == S_WAIT) begin
                if (ic_ack) begin
                    state_d   = S_ISSUE;
                    discard_d = 1'b0;
                end else begin
                    discard_d = 1'b1;
                end
            end
        end else begin
            case (state_q)
                S_ISSUE: begin
                    if (pulse) begin
                        req_pc_d = pc_q;
                        if (ic_ack) begin
                            if_valid_d = 1'b1;
                            if_inst_d  = ic_inst;
                            if_pc_d    = pc_q;
                            pc_d       = pc_q + 32'd4;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (ic_ack) begin
                        state_d = S_ISSUE;
                        if (discard_q) begin
                            discard_d = 1'b0;
                        end else begin
                            if_valid_d = 1'b1;
                            if_inst_d  = ic_inst;
                            if_pc_d    = req_pc_q;
                            pc_d       = req_pc_q + 32'd4;
                        end
                    end
                end
                default: state_d = S_ISSUE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_ISSUE;
            pc_q       <= RESET_PC;
            req_pc_q   <= 32'h0;
            discard_q  <= 1'b0;
            if_valid_q <= 1'b0;
            if_inst_q  <= 32'h0;
            if_pc_q    <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            discard_q  <= discard_d;
            if_valid_q <= if_valid_d;
            if_inst_q  <= if_inst_d;
            if_pc_q    <= if_pc_d;
        end
    end

endmodule
